// File: rtl/run_det_pkg.sv
// Shared types and width helpers for the run-length detector channels.
package run_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMING  = 2'b01,
    ST_ASSERT  = 2'b10,
    ST_HOLDOFF = 2'b11
  } state_e;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_THRESH   = 2;
  localparam int DEF_HOLD     = 0;

  // Run counter only ever needs to reach THRESH.
  function automatic int cnt_width(input int thresh);
    return (thresh < 1) ? 1 : $clog2(thresh + 1);
  endfunction

  // Hold-off counter reaches HOLD; keep at least one bit when HOLD is zero.
  function automatic int hcnt_width(input int hold);
    int w;
    w = $clog2(hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // out_z is high whenever the channel is in a detect state.
  function automatic logic is_detect(input state_e s);
    return (s == ST_ASSERT) || (s == ST_HOLDOFF);
  endfunction

endpackage

// File: rtl/run_detector_channel.sv
// One detector channel: run counter, hold-off counter and rise/fall pulses.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no run in progress, in_y sampled here to pick fast/slow path
//   ARMING  | slow path, counting consecutive in_x-high cycles
//   ASSERT  | detected, out_z high while in_x stays high
//   HOLDOFF | in_x dropped, out_z held high for up to HOLD low cycles
module run_detector_channel
  import run_det_pkg::*;
#(
  parameter int THRESH = DEF_THRESH,
  parameter int HOLD   = DEF_HOLD
) (
  input  logic clk,
  input  logic reset_b,
  input  logic clr,
  input  logic in_x,
  input  logic in_y,
  output logic out_z,
  output logic out_rise,
  output logic out_fall
);

  localparam int CW = cnt_width(THRESH);
  localparam int HW = hcnt_width(HOLD);

  localparam logic [CW-1:0] CNT_MAX  = CW'(THRESH);
  localparam logic [CW-1:0] CNT_LAST = CW'(THRESH - 1);
  localparam logic [HW-1:0] HCNT_MAX = HW'(HOLD);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  logic            z_cur;
  logic            z_nxt;
  logic            run_done;
  logic            hold_done;
  logic [CW-1:0]   cnt_inc;
  logic [HW-1:0]   hcnt_inc;

  // Saturating increments keep both counters from wrapping.
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign hcnt_inc  = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + HW'(1);

  // cnt_q + 1 >= THRESH, expressed without widening the counter.
  assign run_done  = (cnt_q >= CNT_LAST);
  assign hold_done = (hcnt_q == HCNT_MAX);

  // Next-state and counter update; clr overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;

    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_x) begin
            if (!in_y) begin
              state_d = ST_ASSERT;
            end else begin
              cnt_d   = CW'(1);
              state_d = (THRESH <= 1) ? ST_ASSERT : ST_ARMING;
            end
          end
        end
        ST_ARMING: begin
          if (!in_x) begin
            state_d = ST_IDLE;
          end else if (run_done) begin
            state_d = ST_ASSERT;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_ASSERT: begin
          if (!in_x) begin
            if (HOLD == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_HOLDOFF;
              hcnt_d  = HW'(1);
            end
          end
        end
        ST_HOLDOFF: begin
          if (in_x) begin
            state_d = ST_ASSERT;
            hcnt_d  = '0;
          end else if (hold_done) begin
            state_d = ST_IDLE;
          end else begin
            hcnt_d = hcnt_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Both counters restart from zero whenever the channel returns to IDLE.
    if (state_d == ST_IDLE) begin
      cnt_d  = '0;
      hcnt_d = '0;
    end
  end

  // Pulses are computed from the level change so they line up with out_z.
  always_comb begin
    z_cur  = is_detect(state_q);
    z_nxt  = is_detect(state_d);
    rise_d = z_nxt & ~z_cur;
    fall_d = z_cur & ~z_nxt;
  end

  // State, counters and pulse registers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign out_z    = z_cur;
  assign out_rise = rise_q;
  assign out_fall = fall_q;

endmodule

// File: rtl/run_length_detector.sv
// Multi-channel run-length detector: independent channels plus an any-detect flag.
module run_length_detector
  import run_det_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int THRESH   = DEF_THRESH,
  parameter int HOLD     = DEF_HOLD
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                clr,
  input  logic [CHANNELS-1:0] in_x,
  input  logic [CHANNELS-1:0] in_y,
  output logic [CHANNELS-1:0] out_z,
  output logic [CHANNELS-1:0] out_rise,
  output logic [CHANNELS-1:0] out_fall,
  output logic                any_z
);

  logic [CHANNELS-1:0] clr_ch;

  assign clr_ch = {CHANNELS{clr}};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    run_detector_channel #(
      .THRESH (THRESH),
      .HOLD   (HOLD)
    ) u_ch (
      .clk      (clk),
      .reset_b  (reset_b),
      .clr      (clr_ch[g]),
      .in_x     (in_x[g]),
      .in_y     (in_y[g]),
      .out_z    (out_z[g]),
      .out_rise (out_rise[g]),
      .out_fall (out_fall[g])
    );
  end

  assign any_z = |out_z;

endmodule
